// File: rtl/line_decoder_pkg.sv
// line_decoder_pkg: shared widths, one-hot type and decode helper.
// Build macro LINE_DECODER_REG_OUT_EN selects the registered F.
package line_decoder_pkg;

  localparam int SEL_W = 3;
  localparam int OUT_W = 8;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [OUT_W-1:0] onehot_t;

  function automatic onehot_t decode(
    input logic en,
    input sel_t sel
  );
    onehot_t r;
    r = '0;
    if (en) r[sel] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/line_decoder_if.sv
// line_decoder_if: groups Enable, A, B, C and F of the decoder.
// master drives the selects and observes F; slave is the decoder side.
interface line_decoder_if;
  import line_decoder_pkg::*;

  logic    Enable;
  logic    A;
  logic    B;
  logic    C;
  onehot_t F;

  modport master (
    output Enable, A, B, C,
    input  F
  );

  modport slave (
    input  Enable, A, B, C,
    output F
  );

endinterface

// File: rtl/line_decoder_core.sv
// line_decoder_core: combinational 3-to-8 one-hot decode.
// Ports: Enable, sel[2:0] in; onehot[7:0] out (zero when disabled).
module line_decoder_core
  import line_decoder_pkg::*;
(
  input  logic    Enable,
  input  sel_t    sel,
  output onehot_t onehot
);

  always_comb begin
    onehot = '0;
    unique case (1'b1)
      !Enable: onehot = '0;
      default: onehot = decode(1'b1, sel);
    endcase
  end

endmodule

// File: rtl/line_decoder_top.sv
// line_decoder_top: decoder with optional output register.
// Ports: clk, rst_n, Enable, A, B, C in; F[7:0] out. Macro LINE_DECODER_REG_OUT_EN.
module line_decoder_top
  import line_decoder_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    Enable,
  input  logic    A,
  input  logic    B,
  input  logic    C,
  output onehot_t F
);

  sel_t    sel;
  onehot_t f_d;

  assign sel = {A, B, C};

  line_decoder_core u_core (
    .Enable (Enable),
    .sel    (sel),
    .onehot (f_d)
  );

`ifdef LINE_DECODER_REG_OUT_EN
  onehot_t f_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_q <= '0;
    else        f_q <= f_d;
  end

  assign F = f_q;
`else
  // Clock and reset exist only to keep the port list stable.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;
  assign F = f_d;
`endif

endmodule

// File: tb/tb_line_decoder_top.sv
// tb_line_decoder_top: directed and random checks of line_decoder_top.
// Works for both the registered and the combinational build.
module tb_line_decoder_top;
  import line_decoder_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   passed;

  line_decoder_if bus ();

  line_decoder_top dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Enable (bus.Enable),
    .A      (bus.A),
    .B      (bus.B),
    .C      (bus.C),
    .F      (bus.F)
  );

  initial begin
    clk = 1'b0;
    #10 clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic drive(input logic en, input logic [2:0] s);
    bus.Enable = en;
    {bus.A, bus.B, bus.C} = s;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic en, input logic [2:0] s);
    logic [7:0] r;
    r = 8'h00;
    if (en) r = 8'h01 << s;
    return r;
  endfunction

  logic [7:0] exp_f;
  logic       ren;
  logic [2:0] rsel;

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    drive(1'b0, 3'b001);
    #1;
`ifdef LINE_DECODER_REG_OUT_EN
    check("reset_state", bus.F, 8'h00);
    #1 rst_n = 1'b1;
    #3;
    check("pre_edge_5ns", bus.F, 8'h00);
    tick();
    check("disabled_001", bus.F, 8'h00);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i));
      tick();
      check($sformatf("sweep_%0d", i), bus.F, 8'h01 << i);
    end

    drive(1'b1, 3'b010);
    #2;
    check("hold_between_edges", bus.F, 8'h80);
    tick();
    check("load_010", bus.F, 8'h04);

    drive(1'b1, 3'b101);
    tick();
    check("load_101", bus.F, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_now", bus.F, 8'h00);
    drive(1'b1, 3'b111);
    tick();
    check("reset_held_edge", bus.F, 8'h00);
    #3 rst_n = 1'b1;
    #1;
    check("after_release", bus.F, 8'h00);
    drive(1'b1, 3'b110);
    tick();
    check("first_edge_load", bus.F, 8'h40);

    drive(1'b1, 3'b011);
    tick();
    check("simul_before", bus.F, 8'h08);
    drive(1'b0, 3'b110);
    tick();
    check("simul_en_fall", bus.F, 8'h00);

    drive(1'b0, 3'b000);
    tick();
    for (int i = 0; i < 40; i++) begin
      ren  = 1'($urandom_range(0, 1));
      rsel = 3'($urandom_range(0, 7));
      drive(ren, rsel);
      exp_f = model(ren, rsel);
      tick();
      check($sformatf("rand_exact_%0d", i), bus.F, exp_f);
      check($sformatf("rand_onehot0_%0d", i),
            {7'd0, $onehot0(bus.F)}, 8'h01);
    end
`else
    check("comb_reset_dis", bus.F, 8'h00);
    rst_n = 1'b1;
    drive(1'b1, 3'b010);
    #1;
    check("comb_010", bus.F, 8'h04);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i));
      #1;
      check($sformatf("comb_sweep_%0d", i), bus.F, 8'h01 << i);
    end
    drive(1'b0, 3'b110);
    #1;
    check("comb_disabled", bus.F, 8'h00);
    for (int i = 0; i < 40; i++) begin
      ren  = 1'($urandom_range(0, 1));
      rsel = 3'($urandom_range(0, 7));
      drive(ren, rsel);
      exp_f = model(ren, rsel);
      tick();
      check($sformatf("comb_rand_%0d", i), bus.F, exp_f);
      check($sformatf("comb_onehot0_%0d", i),
            {7'd0, $onehot0(bus.F)}, 8'h01);
    end
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
